// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus interface.
// Holds the FSM state encoding, funct3 access-size codes and the alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Undefined funct3 encodings behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = offset[0];
            default:       mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes and replicated write data, plus load
// byte/half extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb      = 4'b1111;
        lane_wdata = wdata;
        load_data  = rdata;
        case (funct3)
            F3_LB, F3_LBU: begin
                wstrb      = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
            end
            F3_LH, F3_LHU: begin
                wstrb      = 4'b0011 << offset;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns the writeback memory request into a word-aligned
// valid/ready bus transaction and returns extended load data, with a watchdog.
module lsu_bus_if
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [2:0]  lsu_funct3,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_stall,
    output logic        lsu_misaligned,
    output logic        lsu_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    lsu_state_e  state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        fault_q;
    logic        valid_q;
    logic [31:0] bus_addr_q;
    logic        bus_we_q;
    logic [3:0]  bus_wstrb_q;
    logic [31:0] bus_wdata_q;

    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [3:0]  wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        mis_now;
    logic        timeout_hit;

    // One aligner serves both directions: live request fields while idle,
    // latched fields while the access is in flight.
    assign sel_f3  = (state_q == IDLE) ? lsu_funct3 : f3_q;
    assign sel_off = (state_q == IDLE) ? lsu_addr[1:0] : off_q;

    lsu_lane_align u_align (
        .funct3     (sel_f3),
        .offset     (sel_off),
        .wdata      (lsu_wdata),
        .rdata      (bus_rdata),
        .wstrb      (wstrb),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    assign mis_now     = (state_q == IDLE) && lsu_req && is_misaligned(lsu_funct3, lsu_addr[1:0]);
    assign timeout_hit = (cnt_q >= CNT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            valid_q     <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_we_q    <= 1'b0;
            bus_wstrb_q <= 4'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu_req && !is_misaligned(lsu_funct3, lsu_addr[1:0])) begin
                        state_q     <= REQ;
                        cnt_q       <= 8'd0;
                        f3_q        <= lsu_funct3;
                        off_q       <= lsu_addr[1:0];
                        valid_q     <= 1'b1;
                        bus_addr_q  <= {lsu_addr[31:2], 2'b00};
                        bus_we_q    <= lsu_we;
                        bus_wstrb_q <= lsu_we ? wstrb : 4'b0000;
                        bus_wdata_q <= lane_wdata;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A response cannot arrive before acceptance, so the watchdog wins here.
                    if (timeout_hit) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        rdata_q <= 32'd0;
                    end else if (bus_ready) begin
                        state_q <= WAIT;
                        valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (bus_rvalid) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= load_data;
                    end else if (timeout_hit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        rdata_q <= 32'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_rdata      = rdata_q;
    assign lsu_done       = done_q | mis_now;
    assign lsu_misaligned = mis_now;
    assign lsu_fault      = fault_q;
    assign lsu_stall      = lsu_req & ~lsu_done;
    assign bus_valid      = valid_q;
    assign bus_addr       = bus_addr_q;
    assign bus_we         = bus_we_q;
    assign bus_wstrb      = bus_wstrb_q;
    assign bus_wdata      = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if: transaction-level model with per-cycle
// expectations, directed corner cases and randomized accesses.
module tb_lsu_bus_if;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000000;

    logic        clk;
    logic        rst;
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_stall;
    logic        lsu_misaligned;
    logic        lsu_fault;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    lsu_bus_if #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_req        (lsu_req),
        .lsu_we         (lsu_we),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_funct3     (lsu_funct3),
        .lsu_rdata      (lsu_rdata),
        .lsu_done       (lsu_done),
        .lsu_stall      (lsu_stall),
        .lsu_misaligned (lsu_misaligned),
        .lsu_fault      (lsu_fault),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_addr       (bus_addr),
        .bus_we         (bus_we),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic chk_en;

    // Expectations for the current cycle, written by the driver after each posedge.
    logic        exp_valid, exp_done, exp_fault, exp_mis, exp_stall, exp_reset;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic        chk_wdata;
    logic [31:0] exp_wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    // Hand-computed literal expectations for the directed cases.
    logic        lit_r_en, lit_b_en;
    logic [31:0] lit_rdata, lit_addr, lit_wdata;
    logic [3:0]  lit_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_valid", {31'd0, bus_valid}, {31'd0, exp_valid});
            check("lsu_done", {31'd0, lsu_done}, {31'd0, exp_done});
            check("lsu_fault", {31'd0, lsu_fault}, {31'd0, exp_fault});
            check("lsu_misaligned", {31'd0, lsu_misaligned}, {31'd0, exp_mis});
            check("lsu_stall", {31'd0, lsu_stall}, {31'd0, exp_stall});
            if (exp_reset) begin
                check("reset_rdata", lsu_rdata, 32'd0);
                check("reset_bus_addr", bus_addr, 32'd0);
                check("reset_bus_we", {31'd0, bus_we}, 32'd0);
                check("reset_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
                check("reset_bus_wdata", bus_wdata, 32'd0);
            end
            if (exp_valid) begin
                check("bus_addr", bus_addr, exp_addr);
                check("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
                check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, exp_wstrb});
                if (chk_wdata) check("bus_wdata", bus_wdata, exp_wdata);
            end
            if (chk_rdata) check("lsu_rdata", lsu_rdata, exp_rdata);
            if (lit_r_en && exp_done) check("lit_rdata", lsu_rdata, lit_rdata);
            if (lit_b_en && exp_valid) begin
                check("lit_bus_addr", bus_addr, lit_addr);
                check("lit_bus_wstrb", {28'd0, bus_wstrb}, {28'd0, lit_wstrb});
                check("lit_bus_wdata", bus_wdata, lit_wdata);
                check("lit_bus_we", {31'd0, bus_we}, 32'd1);
            end
        end
    end

    // Reference model: access size in bytes and lane arithmetic.
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [31:0] word);
        longint n, span, v;
        n = longint'(size_of(f3));
        if (n == 4) return word;
        span = longint'(1) << (8 * n);
        v = (longint'(word) >> (8 * off)) % span;
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input int off);
        int n;
        n = size_of(f3);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = size_of(f3);
        if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic set_idle_exp();
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_fault = 1'b0;
        exp_mis   = 1'b0;
        exp_stall = 1'b0;
        exp_reset = 1'b0;
        chk_wdata = 1'b0;
        chk_rdata = 1'b0;
    endtask

    // dr/dv: cycles of bus_ready / bus_rvalid delay (negative = never).
    // rst_at: cycle at which reset is pulsed (negative = no reset).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int dr, input int dv, input int rst_at);
        int a, v, d, vend, off;
        logic flt;
        off  = int'(addr % 4);
        a    = (dr < 0) ? NEVER : 1 + dr;
        v    = (dr < 0 || dv < 0) ? NEVER : a + 1 + dv;
        flt  = (a >= TIMEOUT) || (v > TIMEOUT);
        d    = flt ? TIMEOUT + 1 : v + 1;
        vend = (a < TIMEOUT) ? a : TIMEOUT;
        for (int c = 0; c <= d + 2; c++) begin
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                rst        = 1'b1;
                lsu_req    = 1'b0;
                bus_ready  = 1'b0;
                bus_rvalid = 1'b0;
                set_idle_exp();
                exp_reset = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                set_idle_exp();
                break;
            end
            lsu_req    = (c <= d);
            lsu_we     = we;
            lsu_funct3 = f3;
            lsu_addr   = addr;
            lsu_wdata  = wd;
            bus_ready  = (c == a);
            bus_rvalid = (c == v) || (flt && c == d + 1);
            bus_rdata  = (c == v) ? rd : $urandom;
            exp_valid  = (c >= 1 && c <= vend);
            exp_done   = (c == d);
            exp_fault  = flt && (c == d);
            exp_mis    = 1'b0;
            exp_stall  = (c < d);
            exp_reset  = 1'b0;
            exp_addr   = addr - (addr % 4);
            exp_we     = we;
            exp_wstrb  = we ? model_strb(f3, off) : 4'b0000;
            chk_wdata  = we;
            exp_wdata  = model_wdata(f3, wd);
            chk_rdata  = (c == d) && (flt || !we);
            exp_rdata  = flt ? 32'd0 : model_load(f3, off, rd);
        end
        lsu_req    = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        set_idle_exp();
    endtask

    task automatic run_mis(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk);
        #1;
        lsu_req    = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = $urandom;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        set_idle_exp();
        exp_mis  = 1'b1;
        exp_done = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            lsu_req = 1'b0;
            set_idle_exp();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst        = 1'b1;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_addr   = 32'd0;
        lsu_wdata  = 32'd0;
        lsu_funct3 = 3'd0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        lit_r_en   = 1'b0;
        lit_b_en   = 1'b0;
        lit_rdata  = 32'd0;
        lit_addr   = 32'd0;
        lit_wdata  = 32'd0;
        lit_wstrb  = 4'd0;
        exp_addr   = 32'd0;
        exp_we     = 1'b0;
        exp_wstrb  = 4'd0;
        exp_wdata  = 32'd0;
        exp_rdata  = 32'd0;
        chk_en     = 1'b0;
        set_idle_exp();

        repeat (2) @(posedge clk);
        #1;
        exp_reset = 1'b1;
        chk_en    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_idle_exp();

        // LW, zero-delay bus
        lit_r_en  = 1'b1;
        lit_rdata = 32'hDEAD_BEEF;
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0, -1);
        // LB / LBU at byte 3
        lit_rdata = 32'hFFFF_FF80;
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 0, -1);
        lit_rdata = 32'h0000_0080;
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h8011_2233, 1, 2, -1);
        lit_r_en = 1'b0;

        // SH at upper half
        lit_b_en  = 1'b1;
        lit_addr  = 32'h0000_0200;
        lit_wstrb = 4'b1100;
        lit_wdata = 32'hABCD_ABCD;
        run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 0, 0, -1);
        lit_b_en = 1'b0;

        // Misaligned word load
        run_mis(1'b0, 3'b010, 32'h0000_0101);

        // Watchdog: ready never, rvalid never, rvalid on the last allowed cycle
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h1111_2222, -1, 0, -1);
        run_txn(1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 32'd0, 1, -1, -1);
        run_txn(1'b0, 3'b101, 32'h0000_0306, 32'd0, 32'h9876_5432, 0, 14, -1);

        // Reset while waiting for the response, then a clean LW
        run_txn(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h5555_AAAA, 0, 10, 3);
        lit_r_en  = 1'b1;
        lit_rdata = 32'h0BAD_F00D;
        run_txn(1'b0, 3'b010, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, 0, 0, -1);
        lit_r_en = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] ad;
            w  = ($urandom_range(0, 2) == 0);
            f  = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            ad = $urandom;
            if ($urandom_range(0, 1) == 1) ad = ad & ~(32'(size_of(f)) - 32'd1);
            if ((ad % 32'(size_of(f))) != 0)
                run_mis(w, f, ad);
            else
                run_txn(w, f, ad, $urandom, $urandom, $urandom_range(0, 4),
                        $urandom_range(0, 4), -1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
